// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec boot-configuration sequencer.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        LOAD,
        SEND,
        WAIT_RSP,
        DONE,
        FAIL
    } state_t;

    typedef struct packed {
        logic [15:0] reg_addr;
        logic [7:0]  data;
    } entry_t;

    localparam logic       I2C_WRITE = 1'b0;
    localparam logic [1:0] B_DEV     = 2'd0;
    localparam logic [1:0] B_REG_HI  = 2'd1;
    localparam logic [1:0] B_REG_LO  = 2'd2;
    localparam logic [1:0] B_DATA    = 2'd3;

    // Byte b of the 4-byte I2C write transaction that programs entry e.
    function automatic logic [7:0] entry_byte(entry_t e, logic [1:0] b, logic [6:0] dev);
        case (b)
            B_DEV:    return {dev, I2C_WRITE};
            B_REG_HI: return e.reg_addr[15:8];
            B_REG_LO: return e.reg_addr[7:0];
            default:  return e.data;
        endcase
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// Byte command / response channel between the sequencer and the I2C master.
interface codec_cfg_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_start;
    logic       cmd_stop;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ack;

    modport master (
        output cmd_valid, cmd_start, cmd_stop, cmd_data,
        input  cmd_ready, rsp_valid, rsp_ack
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_stop, cmd_data,
        output cmd_ready, rsp_valid, rsp_ack
    );
endinterface

// File: rtl/codec_cfg_rom.sv
// Codec init list: register/data pairs, registered read with one cycle of latency.
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 16
) (
    input  logic       clk,
    input  logic       rd_en,
    input  logic [7:0] rd_addr,
    output entry_t     rd_data
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);

    // Power-up, clocking and output-path bring-up order for the codec.
    function automatic entry_t init_entry(logic [7:0] idx);
        case (idx)
            8'd0:    return {16'h4000, 8'h01};
            8'd1:    return {16'h4015, 8'h01};
            8'd2:    return {16'h4016, 8'h00};
            8'd3:    return {16'h4017, 8'h00};
            8'd4:    return {16'h400A, 8'h01};
            8'd5:    return {16'h400B, 8'h05};
            8'd6:    return {16'h400C, 8'h01};
            8'd7:    return {16'h400D, 8'h05};
            8'd8:    return {16'h401C, 8'h21};
            8'd9:    return {16'h401E, 8'h41};
            8'd10:   return {16'h4023, 8'hE7};
            8'd11:   return {16'h4024, 8'hE7};
            8'd12:   return {16'h4025, 8'hE7};
            8'd13:   return {16'h4026, 8'hE7};
            8'd14:   return {16'h4019, 8'h03};
            8'd15:   return {16'h40F9, 8'h7F};
            default: return {16'h4000 | {8'h00, idx}, 8'h00};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= (rd_addr <= LAST_IDX) ? init_entry(rd_addr) : '0;
        end
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Boot-time codec configuration sequencer: walks the init table and issues I2C writes.
// Optional NACK retry is enabled by defining CODEC_CFG_RETRY_EN.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_ENTRIES   = 16,
    parameter logic [6:0] DEV_ADDR      = 7'h3B,
    parameter int         STARTUP_DELAY = 1024,
    parameter int         MAX_RETRIES   = 3
) (
    input  logic                         clk,
    input  logic                         arstn,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [7:0]                   entry_idx,
    codec_cfg_sequencer_if.master        cmd_if
);

    localparam int         DW       = $clog2(STARTUP_DELAY + 2);
    localparam logic [7:0] LAST_IDX = 8'(NUM_ENTRIES - 1);

    state_t        state, state_d;
    logic [DW-1:0] delay_cnt, delay_cnt_d;
    logic [1:0]    byte_cnt, byte_cnt_d;
    logic [1:0]    next_byte;
    logic          busy_d, done_d, error_d;
    logic [7:0]    entry_idx_d;
    logic          cmd_valid_d, cmd_start_d, cmd_stop_d;
    logic [7:0]    cmd_data_d;
    logic          rom_rd_en;
    entry_t        rom_q;
`ifdef CODEC_CFG_RETRY_EN
    localparam int RW = $clog2(MAX_RETRIES + 2);
    logic [RW-1:0] retry_cnt, retry_cnt_d;
`endif

    assign rom_rd_en = (state == LOAD);
    assign next_byte = byte_cnt + 2'd1;

    codec_cfg_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (
        .clk     (clk),
        .rd_en   (rom_rd_en),
        .rd_addr (entry_idx),
        .rd_data (rom_q)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= IDLE;
        else        state <= state_d;
    end

    // Every output is computed one cycle ahead so the channel sees only flop outputs.
    always_comb begin
        state_d     = state;
        delay_cnt_d = delay_cnt;
        byte_cnt_d  = byte_cnt;
        done_d      = done;
        error_d     = error;
        entry_idx_d = entry_idx;
        cmd_valid_d = cmd_if.cmd_valid;
        cmd_start_d = cmd_if.cmd_start;
        cmd_stop_d  = cmd_if.cmd_stop;
        cmd_data_d  = cmd_if.cmd_data;
`ifdef CODEC_CFG_RETRY_EN
        retry_cnt_d = retry_cnt;
`endif
        case (state)
            IDLE, DONE, FAIL: begin
                if (start) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    entry_idx_d = 8'd0;
`ifdef CODEC_CFG_RETRY_EN
                    retry_cnt_d = '0;
`endif
                    if (STARTUP_DELAY == 0) begin
                        state_d = LOAD;
                    end else begin
                        state_d     = DELAY;
                        delay_cnt_d = DW'(STARTUP_DELAY);
                    end
                end
            end
            DELAY: begin
                if (delay_cnt <= DW'(1)) state_d = LOAD;
                else                     delay_cnt_d = delay_cnt - DW'(1);
            end
            LOAD: begin
                byte_cnt_d  = B_DEV;
                state_d     = SEND;
                cmd_valid_d = 1'b1;
                cmd_start_d = 1'b1;
                cmd_stop_d  = 1'b0;
                cmd_data_d  = {DEV_ADDR, I2C_WRITE};
            end
            SEND: begin
                if (cmd_if.cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (cmd_if.rsp_valid) begin
                    if (cmd_if.rsp_ack) begin
                        if (byte_cnt != B_DATA) begin
                            byte_cnt_d  = next_byte;
                            state_d     = SEND;
                            cmd_valid_d = 1'b1;
                            cmd_start_d = 1'b0;
                            cmd_stop_d  = (next_byte == B_DATA);
                            cmd_data_d  = entry_byte(rom_q, next_byte, DEV_ADDR);
                        end else if (entry_idx == LAST_IDX) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            entry_idx_d = entry_idx + 8'd1;
`ifdef CODEC_CFG_RETRY_EN
                            retry_cnt_d = '0;
`endif
                            state_d     = LOAD;
                        end
                    end else begin
`ifdef CODEC_CFG_RETRY_EN
                        if (retry_cnt < RW'(MAX_RETRIES)) begin
                            retry_cnt_d = retry_cnt + RW'(1);
                            state_d     = LOAD;
                        end else begin
                            state_d = FAIL;
                            error_d = 1'b1;
                        end
`else
                        state_d = FAIL;
                        error_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == DELAY) || (state_d == LOAD) ||
                 (state_d == SEND)  || (state_d == WAIT_RSP);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            delay_cnt        <= '0;
            byte_cnt         <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            entry_idx        <= 8'd0;
            cmd_if.cmd_valid <= 1'b0;
            cmd_if.cmd_start <= 1'b0;
            cmd_if.cmd_stop  <= 1'b0;
            cmd_if.cmd_data  <= 8'd0;
`ifdef CODEC_CFG_RETRY_EN
            retry_cnt        <= '0;
`endif
        end else begin
            delay_cnt        <= delay_cnt_d;
            byte_cnt         <= byte_cnt_d;
            busy             <= busy_d;
            done             <= done_d;
            error            <= error_d;
            entry_idx        <= entry_idx_d;
            cmd_if.cmd_valid <= cmd_valid_d;
            cmd_if.cmd_start <= cmd_start_d;
            cmd_if.cmd_stop  <= cmd_stop_d;
            cmd_if.cmd_data  <= cmd_data_d;
`ifdef CODEC_CFG_RETRY_EN
            retry_cnt        <= retry_cnt_d;
`endif
        end
    end

endmodule
